monster_dir_ctrl: RTL and testbench



---
 rtl/monster_dir_ctrl_if.sv | 33 +++
 rtl/monster_dir_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_monster_dir_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/monster_dir_ctrl_if.sv
// Bundle of the per-monster decision signals shared between the game logic
// and the direction controller.
//   startOfFrame     : one-clock pulse per video frame
//   monsterTopLeftX/Y: monster position, signed pixels
//   pacmanTopLeftX/Y : Pac-Man position, signed pixels
//   collision        : monster hit a wall this clock
//   frightReq        : one-clock pulse when a power pellet is eaten
//   direction_key    : chosen direction (00 up, 01 down, 10 right, 11 left)
//   mode             : 00 IDLE, 01 SCATTER, 10 CHASE, 11 FRIGHT
// master drives the game-side inputs; slave is the controller.
interface monster_dir_ctrl_if;
  logic               startOfFrame;
  logic signed [10:0] monsterTopLeftX;
  logic signed [10:0] monsterTopLeftY;
  logic signed [10:0] pacmanTopLeftX;
  logic signed [10:0] pacmanTopLeftY;
  logic               collision;
  logic               frightReq;
  logic [1:0]         direction_key;
  logic [1:0]         mode;

  modport master (
    output startOfFrame, monsterTopLeftX, monsterTopLeftY,
    output pacmanTopLeftX, pacmanTopLeftY, collision, frightReq,
    input  direction_key, mode
  );

  modport slave (
    input  startOfFrame, monsterTopLeftX, monsterTopLeftY,
    input  pacmanTopLeftX, pacmanTopLeftY, collision, frightReq,
    output direction_key, mode
  );
endinterface

// File: rtl/monster_dir_ctrl.sv
// Direction "brain" for one monster. Runs the scatter / chase / fright mode
// timer and, once per decision interval (or right after a wall hit), picks
// the direction_key for the monster's movement block.
// Ports:
//   clk    : system clock
//   resetN : synchronous active-low reset
//   bus    : monster_dir_ctrl_if.slave (frame pulse, positions, collision,
//            frightReq in; registered direction_key and mode out)
module monster_dir_ctrl #(
  parameter logic [1:0]  INITIAL_DIR     = 2'b11,
  parameter int          SCATTER_X       = 600,
  parameter int          SCATTER_Y       = 40,
  parameter int          CHASE_FRAMES    = 600,
  parameter int          SCATTER_FRAMES  = 210,
  parameter int          FRIGHT_FRAMES   = 180,
  parameter int          DECISION_PERIOD = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic              clk,
  input logic              resetN,
  monster_dir_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_SCATTER = 2'b01,
    MODE_CHASE   = 2'b10,
    MODE_FRIGHT  = 2'b11
  } mode_e;

  localparam logic signed [11:0] SCAT_X      = 12'(SCATTER_X);
  localparam logic signed [11:0] SCAT_Y      = 12'(SCATTER_Y);
  localparam logic [15:0]        CHASE_LAST  = 16'(CHASE_FRAMES - 1);
  localparam logic [15:0]        SCAT_LAST   = 16'(SCATTER_FRAMES - 1);
  localparam logic [15:0]        FRIGHT_LAST = 16'(FRIGHT_FRAMES - 1);
  localparam logic [7:0]         DEC_LAST    = 8'(DECISION_PERIOD - 1);

  // Opposite direction: up<->down and right<->left differ only in bit 0.
  function automatic logic [1:0] opp(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

  // First of four candidates that is not excluded by either enabled
  // exclusion; falls back to the first candidate.
  function automatic logic [1:0] first_free(
    input logic [1:0] c0, input logic [1:0] c1,
    input logic [1:0] c2, input logic [1:0] c3,
    input logic ex_a_en, input logic [1:0] ex_a,
    input logic ex_b_en, input logic [1:0] ex_b
  );
    logic [3:0][1:0] c;
    logic [1:0]      pick;
    logic            found;
    c     = {c3, c2, c1, c0};
    pick  = c0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && !(ex_a_en && (c[i] == ex_a)) && !(ex_b_en && (c[i] == ex_b))) begin
        pick  = c[i];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  mode_e              mode_r, mode_n, saved_r, saved_n;
  logic [1:0]         dir_r, dir_n, bd_r, bd_n;
  logic               bv_r, bv_n, pend_r, pend_n;
  logic [15:0]        timer_r, timer_n, lfsr_r, lfsr_n;
  logic [7:0]         dec_r, dec_n;

  logic signed [11:0] mx_s, my_s, tx_s, ty_s, dx_s, dy_s;
  logic [11:0]        adx_s, ady_s;
  logic [1:0]         xdir_s, ydir_s, prim_s, sec_s, steer_s, fright_s;
  logic               forced_s, lfsr_fb_s;

  // Target selection, distance arithmetic and candidate ranking.
  always_comb begin
    mx_s = {bus.monsterTopLeftX[10], bus.monsterTopLeftX};
    my_s = {bus.monsterTopLeftY[10], bus.monsterTopLeftY};
    if (mode_r == MODE_CHASE) begin
      tx_s = {bus.pacmanTopLeftX[10], bus.pacmanTopLeftX};
      ty_s = {bus.pacmanTopLeftY[10], bus.pacmanTopLeftY};
    end else begin
      tx_s = SCAT_X;
      ty_s = SCAT_Y;
    end
    dx_s  = tx_s - mx_s;
    dy_s  = ty_s - my_s;
    adx_s = dx_s[11] ? (12'd0 - dx_s) : dx_s;
    ady_s = dy_s[11] ? (12'd0 - dy_s) : dy_s;
    // A zero delta maps to right/down, which is the secondary default.
    xdir_s = dx_s[11] ? 2'b11 : 2'b10;
    ydir_s = dy_s[11] ? 2'b00 : 2'b01;
    if (adx_s >= ady_s) begin
      prim_s = xdir_s;
      sec_s  = ydir_s;
    end else begin
      prim_s = ydir_s;
      sec_s  = xdir_s;
    end
    if ((dx_s == 12'sd0) && (dy_s == 12'sd0)) begin
      steer_s = bv_r ? opp(bd_r) : dir_r;
    end else begin
      steer_s = first_free(prim_s, sec_s, opp(sec_s), opp(prim_s),
                           bv_r, bd_r, 1'b0, 2'b00);
    end
    fright_s = first_free(lfsr_r[1:0], lfsr_r[1:0] + 2'd1,
                          lfsr_r[1:0] + 2'd2, lfsr_r[1:0] + 2'd3,
                          bv_r, bd_r, 1'b1, opp(dir_r));
  end

  // Next-state logic: LFSR, mode FSM, decision trigger, collision latch.
  always_comb begin
    mode_n    = mode_r;
    saved_n   = saved_r;
    timer_n   = timer_r;
    dec_n     = dec_r;
    dir_n     = dir_r;
    bv_n      = bv_r;
    bd_n      = bd_r;
    pend_n    = pend_r;
    lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    lfsr_n    = {lfsr_r[14:0], lfsr_fb_s};
    forced_s  = bus.frightReq && ((mode_r == MODE_SCATTER) || (mode_r == MODE_CHASE));

    case (mode_r)
      MODE_IDLE: begin
        if (bus.startOfFrame) begin
          mode_n  = MODE_SCATTER;
          timer_n = 16'd0;
        end else begin
          mode_n = MODE_IDLE;
        end
      end
      MODE_SCATTER, MODE_CHASE: begin
        // frightReq outranks a same-edge timer expiry.
        if (bus.frightReq) begin
          saved_n = mode_r;
          mode_n  = MODE_FRIGHT;
          timer_n = 16'd0;
        end else if (bus.startOfFrame) begin
          if (timer_r == ((mode_r == MODE_SCATTER) ? SCAT_LAST : CHASE_LAST)) begin
            mode_n  = (mode_r == MODE_SCATTER) ? MODE_CHASE : MODE_SCATTER;
            timer_n = 16'd0;
          end else begin
            timer_n = timer_r + 16'd1;
          end
        end else begin
          timer_n = timer_r;
        end
      end
      MODE_FRIGHT: begin
        if (bus.frightReq) begin
          timer_n = 16'd0;
        end else if (bus.startOfFrame) begin
          if (timer_r == FRIGHT_LAST) begin
            mode_n  = saved_r;
            timer_n = 16'd0;
          end else begin
            timer_n = timer_r + 16'd1;
          end
        end else begin
          timer_n = timer_r;
        end
      end
      default: begin
        mode_n  = MODE_IDLE;
        timer_n = 16'd0;
      end
    endcase

    // Decisions use the mode in force before this edge.
    if (forced_s) begin
      dir_n  = opp(dir_r);
      dec_n  = DEC_LAST;
      pend_n = 1'b0;
      bv_n   = 1'b0;
    end else if (bus.startOfFrame && (mode_r != MODE_IDLE)) begin
      if ((dec_r == 8'd0) || pend_r) begin
        dir_n  = (mode_r == MODE_FRIGHT) ? fright_s : steer_s;
        dec_n  = DEC_LAST;
        pend_n = 1'b0;
        bv_n   = 1'b0;
      end else begin
        dec_n = dec_r - 8'd1;
      end
    end else begin
      dec_n = dec_r;
    end

    // Latched after the decision so a same-edge hit steers the next one;
    // the first blocked direction is kept until a decision consumes it.
    if (bus.collision && (mode_r != MODE_IDLE)) begin
      if (!bv_n) begin
        bd_n = dir_r;
      end else begin
        bd_n = bd_r;
      end
      bv_n   = 1'b1;
      pend_n = 1'b1;
    end else begin
      pend_n = pend_n;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      mode_r  <= MODE_IDLE;
      saved_r <= MODE_SCATTER;
      timer_r <= 16'd0;
      dec_r   <= 8'd0;
      dir_r   <= INITIAL_DIR;
      bv_r    <= 1'b0;
      bd_r    <= 2'b00;
      pend_r  <= 1'b0;
      lfsr_r  <= LFSR_SEED;
    end else begin
      mode_r  <= mode_n;
      saved_r <= saved_n;
      timer_r <= timer_n;
      dec_r   <= dec_n;
      dir_r   <= dir_n;
      bv_r    <= bv_n;
      bd_r    <= bd_n;
      pend_r  <= pend_n;
      lfsr_r  <= lfsr_n;
    end
  end

  assign bus.direction_key = dir_r;
  assign bus.mode          = mode_r;

endmodule

// File: tb/tb_monster_dir_ctrl.sv
// Self-checking bench for monster_dir_ctrl: a table of scatter-steering
// vectors, hand-written chase / fright / reset sequences and a randomized
// run, all compared every clock against a behavioural model.
module tb_monster_dir_ctrl;
  localparam logic [1:0]  INIT_DIR = 2'b11;
  localparam int          SCX = 600, SCY = 40, CF = 4, SF = 3, FF = 180, DP = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  monster_dir_ctrl_if bus();

  monster_dir_ctrl #(
    .INITIAL_DIR(INIT_DIR), .SCATTER_X(SCX), .SCATTER_Y(SCY),
    .CHASE_FRAMES(CF), .SCATTER_FRAMES(SF), .FRIGHT_FRAMES(FF),
    .DECISION_PERIOD(DP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  int          m_mode, m_timer, m_dec, m_saved;
  bit          m_pend, m_bv;
  logic [1:0]  m_dir, m_bd;
  logic [15:0] m_lfsr;

  typedef struct {
    logic signed [10:0] mx;
    logic signed [10:0] my;
    logic               coll;
    logic [1:0]         exp_dir;
  } vec_t;
  vec_t vecs[13];
  logic [1:0] mode_seq[11];

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Greedy move toward the target: bigger axis first, ties go to X.
  function automatic logic [1:0] steer(input int mx, input int my, input int tx, input int ty,
                                       input bit bv, input logic [1:0] bd, input logic [1:0] cur);
    int dx, dy;
    logic [1:0] xd, yd, p, s;
    logic [1:0] order[4];
    dx = tx - mx;
    dy = ty - my;
    if (dx == 0 && dy == 0) return bv ? (bd ^ 2'b01) : cur;
    xd = (dx < 0) ? 2'b11 : 2'b10;
    yd = (dy < 0) ? 2'b00 : 2'b01;
    if (iabs(dx) >= iabs(dy)) begin p = xd; s = yd; end
    else begin p = yd; s = xd; end
    order = '{p, s, s ^ 2'b01, p ^ 2'b01};
    for (int i = 0; i < 4; i++) if (!(bv && order[i] == bd)) return order[i];
    return p;
  endfunction

  function automatic logic [1:0] fright_pick(input logic [1:0] r, input bit bv,
                                             input logic [1:0] bd, input logic [1:0] cur);
    logic [1:0] c;
    for (int k = 0; k < 4; k++) begin
      c = 2'((int'(r) + k) % 4);
      if (!(bv && c == bd) && c != (cur ^ 2'b01)) return c;
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_step();
    int         old_mode, limit;
    logic [1:0] old_dir;
    logic [15:0] old_lfsr;
    bit         forced, decided, sof, fr, coll;
    sof = bus.startOfFrame; fr = bus.frightReq; coll = bus.collision;
    if (!resetN) begin
      m_mode = 0; m_timer = 0; m_dec = 0; m_saved = 1; m_pend = 0; m_bv = 0;
      m_bd = 2'b00; m_dir = INIT_DIR; m_lfsr = SEED;
      return;
    end
    old_mode = m_mode; old_dir = m_dir; old_lfsr = m_lfsr;
    m_lfsr  = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    forced  = fr && (old_mode == 1 || old_mode == 2);
    decided = 0;
    if (forced) begin
      m_dir = old_dir ^ 2'b01; decided = 1;
    end else if (sof && old_mode != 0) begin
      if (m_dec == 0 || m_pend) begin
        if (old_mode == 3) m_dir = fright_pick(old_lfsr[1:0], m_bv, m_bd, old_dir);
        else if (old_mode == 2)
          m_dir = steer(int'(bus.monsterTopLeftX), int'(bus.monsterTopLeftY),
                        int'(bus.pacmanTopLeftX), int'(bus.pacmanTopLeftY), m_bv, m_bd, old_dir);
        else
          m_dir = steer(int'(bus.monsterTopLeftX), int'(bus.monsterTopLeftY),
                        SCX, SCY, m_bv, m_bd, old_dir);
        decided = 1;
      end else m_dec = m_dec - 1;
    end
    if (decided) begin m_dec = DP - 1; m_pend = 0; m_bv = 0; end
    if (old_mode == 0) begin
      if (sof) begin m_mode = 1; m_timer = 0; end
    end else if (forced) begin
      m_saved = old_mode; m_mode = 3; m_timer = 0;
    end else if (old_mode == 3 && fr) begin
      m_timer = 0;
    end else if (sof) begin
      limit = (old_mode == 1) ? SF : (old_mode == 2) ? CF : FF;
      if (m_timer + 1 == limit) begin
        m_mode  = (old_mode == 3) ? m_saved : ((old_mode == 1) ? 2 : 1);
        m_timer = 0;
      end else m_timer = m_timer + 1;
    end
    if (coll && old_mode != 0) begin
      if (!m_bv) m_bd = old_dir;
      m_bv = 1; m_pend = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_dir", bus.direction_key, m_dir);
    chk("model_mode", bus.mode, 2'(m_mode));
  endtask

  // Three quiet clocks, then the frame pulse; returns just after its edge.
  task automatic frame();
    bus.startOfFrame = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic pulse_coll();
    bus.collision = 1'b1; tick(); bus.collision = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0; tick(); resetN = 1'b1;
  endtask

  task automatic set_pos(input int mx, input int my, input int px, input int py);
    bus.monsterTopLeftX = 11'(mx); bus.monsterTopLeftY = 11'(my);
    bus.pacmanTopLeftX  = 11'(px); bus.pacmanTopLeftY  = 11'(py);
  endtask

  task automatic drive_rand(input logic sof);
    int pick;
    bus.startOfFrame = sof;
    bus.collision    = ($urandom_range(0, 15) == 0);
    bus.frightReq    = ($urandom_range(0, 299) == 0);
    resetN           = ($urandom_range(0, 1499) != 0);
    if ($urandom_range(0, 15) == 0) begin
      pick = $urandom_range(0, 3);
      bus.pacmanTopLeftX = 11'($urandom_range(0, 2047));
      bus.pacmanTopLeftY = 11'($urandom_range(0, 2047));
      if (pick == 0) begin
        bus.monsterTopLeftX = bus.pacmanTopLeftX; bus.monsterTopLeftY = bus.pacmanTopLeftY;
      end else if (pick == 1) begin
        bus.monsterTopLeftX = 11'(SCX); bus.monsterTopLeftY = 11'(SCY);
      end else begin
        bus.monsterTopLeftX = 11'($urandom_range(0, 2047));
        bus.monsterTopLeftY = 11'($urandom_range(0, 2047));
      end
    end
  endtask

  initial begin
    logic [1:0] prev;
    // Scatter target (600,40); a collision before the decision blocks 11.
    vecs[0]  = '{11'sd100,  11'sd100, 1'b0, 2'b10};
    vecs[1]  = '{11'sd100,  11'sd100, 1'b1, 2'b10};
    vecs[2]  = '{11'sd590,  11'sd300, 1'b0, 2'b00};
    vecs[3]  = '{11'sd700,  11'sd40,  1'b0, 2'b11};
    vecs[4]  = '{11'sd700,  11'sd40,  1'b1, 2'b01};
    vecs[5]  = '{11'sd600,  11'sd40,  1'b0, 2'b11};
    vecs[6]  = '{11'sd600,  11'sd40,  1'b1, 2'b10};
    vecs[7]  = '{11'sd600,  11'sd500, 1'b0, 2'b00};
    vecs[8]  = '{-11'sd500, -11'sd300, 1'b0, 2'b10};
    vecs[9]  = '{11'sd1000, 11'sd40,  1'b1, 2'b01};
    vecs[10] = '{11'sd550,  11'sd90,  1'b0, 2'b10};
    vecs[11] = '{11'sd650,  -11'sd10, 1'b1, 2'b01};
    vecs[12] = '{11'sd600,  11'sd0,   1'b0, 2'b01};
    mode_seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.collision = 1'b0; bus.frightReq = 1'b0;
    set_pos(0, 0, 0, 0);
    tick(); tick();
    resetN = 1'b1;
    chk("reset_dir", bus.direction_key, 2'b11);
    chk("reset_mode", bus.mode, 2'b00);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      set_pos(int'(vecs[i].mx), int'(vecs[i].my), 300, 300);
      frame();
      chk($sformatf("table%0d_mode", i), bus.mode, 2'b01);
      if (vecs[i].coll) pulse_coll();
      frame();
      chk($sformatf("table%0d_dir", i), bus.direction_key, vecs[i].exp_dir);
    end

    // Mode sequence with SCATTER=3, CHASE=4 frames.
    do_reset();
    set_pos(100, 100, 300, 150);
    for (int f = 1; f <= 11; f++) begin
      frame();
      chk($sformatf("mode_seq%0d", f), bus.mode, mode_seq[f-1]);
      if (f == 1) chk("first_sof_dir", bus.direction_key, 2'b11);
    end
    for (int f = 12; f <= 26; f++) frame();
    chk("chase_mode", bus.mode, 2'b10);
    chk("chase_dir", bus.direction_key, 2'b10);
    set_pos(100, 100, 120, 400);
    for (int f = 27; f <= 33; f++) begin
      frame();
      chk($sformatf("hold%0d", f), bus.direction_key, 2'b10);
    end
    frame();
    chk("moved_dir", bus.direction_key, 2'b01);
    set_pos(100, 100, 300, 150);
    for (int f = 35; f <= 42; f++) frame();
    chk("chase_dir2", bus.direction_key, 2'b10);
    pulse_coll();
    chk("coll_no_early", bus.direction_key, 2'b10);
    frame();
    chk("coll_secondary", bus.direction_key, 2'b01);
    for (int f = 44; f <= 53; f++) frame();
    chk("pre_fright_mode", bus.mode, 2'b10);
    chk("pre_fright_dir", bus.direction_key, 2'b10);

    bus.frightReq = 1'b1; tick(); bus.frightReq = 1'b0;
    chk("fright_mode", bus.mode, 2'b11);
    chk("fright_reverse", bus.direction_key, 2'b11);
    prev = bus.direction_key;
    for (int k = 1; k <= FF; k++) begin
      frame();
      chk($sformatf("no_reverse%0d", k), {1'b0, bus.direction_key == (prev ^ 2'b01)}, 2'b00);
      prev = bus.direction_key;
      if (k == FF - 1) chk("fright_still", bus.mode, 2'b11);
    end
    chk("fright_exit", bus.mode, 2'b10);

    bus.frightReq = 1'b1; tick(); bus.frightReq = 1'b0;
    pulse_coll();
    do_reset();
    chk("midreset_mode", bus.mode, 2'b00);
    chk("midreset_dir", bus.direction_key, 2'b11);
    frame();
    chk("after_reset_mode", bus.mode, 2'b01);
    frame();
    chk("after_reset_dir", bus.direction_key, 2'b10);

    for (int f = 0; f < 2500; f++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int c = 0; c < len; c++) begin drive_rand(1'b0); tick(); end
      drive_rand(1'b1); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
